// File: rtl/fx_count_sender.sv
// Counts clk_fx cycles inside the synchronised gate and hands each window's count to clk_fs via toggle req/ack.
// Latency: req_tog toggles 2 edges after gate_in is first sampled low; a window ending while a transfer is outstanding is dropped (overrun).
module fx_count_sender #(
   parameter int          CNT_W       = 30,
   parameter logic [15:0] ACK_TIMEOUT = 16'd1000
) (
   input  logic             clk_fx,
   input  logic             rst_n,
   input  logic             gate_in,
   input  logic             ack_tog,
   output logic             req_tog,
   output logic [CNT_W-1:0] cnt_data,
   output logic             cnt_sat,
   output logic [3:0]       seq,
   output logic             busy,
   output logic             overrun,
   output logic             timeout_err
);

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   logic             gate_m_q, gate_m_d, gate_s_q, gate_s_d, gate_d_q, gate_d_d;
   logic             ack_m_q, ack_m_d, ack_s_q, ack_s_d;
   logic [1:0]       prime_q, prime_d;
   logic             armed_q, armed_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sat_q, sat_d;
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_data_q, cnt_data_d;
   logic             cnt_sat_q, cnt_sat_d;
   logic [3:0]       seq_q, seq_d;
   logic             req_tog_q, req_tog_d;
   logic             busy_q, busy_d;
   logic             overrun_q, overrun_d;
   logic             timeout_err_q, timeout_err_d;
   logic [15:0]      wait_q, wait_d;
   logic             rise, fall, win_end;

   assign rise    = gate_s_q & ~gate_d_q;
   assign fall    = ~gate_s_q & gate_d_q;
   assign win_end = armed_q & fall;

   always_comb begin
      gate_m_d      = gate_in;
      gate_s_d      = gate_m_q;
      gate_d_d      = gate_s_q;
      ack_m_d       = ack_tog;
      ack_s_d       = ack_m_q;
      prime_d       = prime_q;
      armed_d       = armed_q;
      cnt_d         = cnt_q;
      sat_d         = sat_q;
      state_d       = state_q;
      cnt_data_d    = cnt_data_q;
      cnt_sat_d     = cnt_sat_q;
      seq_d         = seq_q;
      req_tog_d     = req_tog_q;
      overrun_d     = 1'b0;
      timeout_err_d = timeout_err_q;
      wait_d        = wait_q;

      // gate_s only holds a real sample of gate_in two edges after reset; arming on
      // the reset value would let a gate already high at release count a partial window.
      if (prime_q != 2'd2) prime_d = prime_q + 2'd1;
      if (prime_q == 2'd2 && !gate_s_q) armed_d = 1'b1;

      if (armed_q && rise) begin
         cnt_d = CNT_W'(1);
         sat_d = 1'b0;
      end else if (armed_q && gate_s_q) begin
         if (&cnt_q) sat_d = 1'b1;
         else        cnt_d = cnt_q + CNT_W'(1);
      end

      case (state_q)
         S_IDLE: begin
            if (win_end) begin
               cnt_data_d = cnt_q;
               cnt_sat_d  = sat_q;
               seq_d      = seq_q + 4'd1;
               req_tog_d  = ~req_tog_q;
               wait_d     = 16'd0;
               state_d    = S_WAIT;
            end
         end
         S_WAIT: begin
            if (win_end) overrun_d = 1'b1;
            if (ack_s_q == req_tog_q) begin
               state_d       = S_IDLE;
               wait_d        = 16'd0;
               timeout_err_d = 1'b0;
            end else if (wait_q != ACK_TIMEOUT) begin
               wait_d = wait_q + 16'd1;
               if (wait_q + 16'd1 == ACK_TIMEOUT) timeout_err_d = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d == S_WAIT);
   end

   always_ff @(posedge clk_fx or negedge rst_n) begin
      if (!rst_n) begin
         gate_m_q      <= 1'b0;
         gate_s_q      <= 1'b0;
         gate_d_q      <= 1'b0;
         ack_m_q       <= 1'b0;
         ack_s_q       <= 1'b0;
         prime_q       <= 2'd0;
         armed_q       <= 1'b0;
         cnt_q         <= '0;
         sat_q         <= 1'b0;
         state_q       <= S_IDLE;
         cnt_data_q    <= '0;
         cnt_sat_q     <= 1'b0;
         seq_q         <= 4'd0;
         req_tog_q     <= 1'b0;
         busy_q        <= 1'b0;
         overrun_q     <= 1'b0;
         timeout_err_q <= 1'b0;
         wait_q        <= 16'd0;
      end else begin
         gate_m_q      <= gate_m_d;
         gate_s_q      <= gate_s_d;
         gate_d_q      <= gate_d_d;
         ack_m_q       <= ack_m_d;
         ack_s_q       <= ack_s_d;
         prime_q       <= prime_d;
         armed_q       <= armed_d;
         cnt_q         <= cnt_d;
         sat_q         <= sat_d;
         state_q       <= state_d;
         cnt_data_q    <= cnt_data_d;
         cnt_sat_q     <= cnt_sat_d;
         seq_q         <= seq_d;
         req_tog_q     <= req_tog_d;
         busy_q        <= busy_d;
         overrun_q     <= overrun_d;
         timeout_err_q <= timeout_err_d;
         wait_q        <= wait_d;
      end
   end

   assign req_tog     = req_tog_q;
   assign cnt_data    = cnt_data_q;
   assign cnt_sat     = cnt_sat_q;
   assign seq         = seq_q;
   assign busy        = busy_q;
   assign overrun     = overrun_q;
   assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_fx_count_sender.sv
// Bench for fx_count_sender: a 30-bit and a 4-bit instance share the gate; a window-level model is compared every cycle.
module tb_fx_count_sender;

   localparam int T_OUT = 1000;

   logic        clk_fx = 1'b0;
   logic        rst_n = 1'b0;
   logic        gate_in = 1'b0;
   logic        loop_en = 1'b1;
   logic        ack_hold = 1'b0;
   logic [2:0]  dly_a = 3'd0, dly_b = 3'd0;
   logic        ack_a, ack_b;

   logic        req_a, sat_a, busy_a, ovr_a, err_a;
   logic [29:0] cnt_a;
   logic [3:0]  seq_a;
   logic        req_b, sat_b, busy_b, ovr_b, err_b;
   logic [3:0]  cnt_b;
   logic [3:0]  seq_b;

   int total = 0;
   int bad = 0;
   int ovr_count = 0;

   always #5 clk_fx = ~clk_fx;

   fx_count_sender #(.CNT_W(30), .ACK_TIMEOUT(16'd1000)) dut_a (
      .clk_fx(clk_fx), .rst_n(rst_n), .gate_in(gate_in), .ack_tog(ack_a),
      .req_tog(req_a), .cnt_data(cnt_a), .cnt_sat(sat_a), .seq(seq_a),
      .busy(busy_a), .overrun(ovr_a), .timeout_err(err_a));

   fx_count_sender #(.CNT_W(4), .ACK_TIMEOUT(16'd1000)) dut_b (
      .clk_fx(clk_fx), .rst_n(rst_n), .gate_in(gate_in), .ack_tog(ack_b),
      .req_tog(req_b), .cnt_data(cnt_b), .cnt_sat(sat_b), .seq(seq_b),
      .busy(busy_b), .overrun(ovr_b), .timeout_err(err_b));

   // Receiver stand-in: echo req_tog back after 3 cycles, or hold a fixed level.
   assign ack_a = loop_en ? dly_a[2] : ack_hold;
   assign ack_b = loop_en ? dly_b[2] : ack_hold;
   always @(negedge clk_fx) begin
      dly_a = {dly_a[1:0], req_a};
      dly_b = {dly_b[1:0], req_b};
   end

   // ---------------- window-level model ----------------
   logic        m_req[2], m_sat[2], m_busy[2], m_ovr[2], m_err[2];
   logic [29:0] m_cnt[2];
   logic [3:0]  m_seq[2];
   int          m_wait[2];
   logic        ah1[2], ah2[2];
   int          ecnt, run, pend_e, pend_len;
   logic        pend_v, win_ok, seen_low, end_now, bo, ro;

   function automatic int kmax(input int k);
      return (k == 0) ? ((1 << 30) - 1) : 15;
   endfunction

   always @(posedge clk_fx or negedge rst_n) begin
      if (!rst_n) begin
         ecnt = 0; run = 0; pend_v = 0; pend_e = 0; pend_len = 0;
         win_ok = 0; seen_low = 0;
         for (int k = 0; k < 2; k++) begin
            m_req[k] = 0; m_sat[k] = 0; m_busy[k] = 0; m_ovr[k] = 0; m_err[k] = 0;
            m_cnt[k] = '0; m_seq[k] = '0; m_wait[k] = 0; ah1[k] = 0; ah2[k] = 0;
         end
      end else begin
         ecnt++;
         end_now = pend_v && (pend_e == ecnt);
         if (end_now) pend_v = 0;
         for (int k = 0; k < 2; k++) begin
            bo = m_busy[k];
            ro = m_req[k];
            m_ovr[k] = 0;
            if (end_now) begin
               if (bo) m_ovr[k] = 1;
               else begin
                  m_cnt[k]  = 30'((pend_len > kmax(k)) ? kmax(k) : pend_len);
                  m_sat[k]  = (pend_len > kmax(k));
                  m_seq[k]  = m_seq[k] + 4'd1;
                  m_req[k]  = ~m_req[k];
                  m_busy[k] = 1;
                  m_wait[k] = 0;
               end
            end
            if (bo) begin
               if (ah2[k] == ro) begin
                  m_busy[k] = 0; m_wait[k] = 0; m_err[k] = 0;
               end else begin
                  if (m_wait[k] < T_OUT) m_wait[k]++;
                  if (m_wait[k] == T_OUT) m_err[k] = 1;
               end
            end
            ah2[k] = ah1[k];
            ah1[k] = (k == 0) ? ack_a : ack_b;
         end
         // a window is a run of high samples that began after some low sample
         if (gate_in) begin
            if (run == 0) win_ok = seen_low;
            run++;
         end else begin
            if (run > 0 && win_ok) begin
               pend_v = 1; pend_e = ecnt + 2; pend_len = run;
            end
            run = 0;
            seen_low = 1;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk_fx) begin
      logic [38:0] act, exp;
      if (rst_n) begin
         if (ovr_a) ovr_count++;
         for (int k = 0; k < 2; k++) begin
            if (k == 0) act = {req_a, cnt_a, sat_a, seq_a, busy_a, ovr_a, err_a};
            else        act = {req_b, 26'd0, cnt_b, sat_b, seq_b, busy_b, ovr_b, err_b};
            exp = {m_req[k], m_cnt[k], m_sat[k], m_seq[k], m_busy[k], m_ovr[k], m_err[k]};
            total++;
            if (act !== exp) begin
               bad++;
               $display("FAIL cycle_cmp inst=%0d t=%0t actual=%h required=%h", k, $time, act, exp);
            end
         end
      end
   end

   task automatic chk(input string nm, input longint act, input longint req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, req);
      end
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, "_a"}, longint'({req_a, cnt_a, sat_a, seq_a, busy_a, ovr_a, err_a}), 0);
      chk({nm, "_b"}, longint'({req_b, cnt_b, sat_b, seq_b, busy_b, ovr_b, err_b}), 0);
   endtask

   task automatic do_reset(input string nm);
      @(negedge clk_fx);
      #2 rst_n = 1'b0;
      ack_hold = 1'b0;
      #1 chk_zero(nm);
      repeat (3) @(negedge clk_fx);
      rst_n = 1'b1;
   endtask

   task automatic window(input int n, input int gap);
      @(negedge clk_fx);
      gate_in = 1'b1;
      repeat (n) @(negedge clk_fx);
      gate_in = 1'b0;
      repeat (gap) @(negedge clk_fx);
   endtask

   initial begin
      repeat (3) @(negedge clk_fx);
      chk_zero("reset_state");
      rst_n = 1'b1;
      repeat (10) @(negedge clk_fx);

      // basic transfer with exact request latency
      window(2000, 0);
      @(negedge clk_fx); chk("lat_req_e0", req_a, 0);
      @(negedge clk_fx); chk("lat_req_e1", req_a, 0);
      @(negedge clk_fx); chk("lat_req_e2", req_a, 1); chk("lat_busy_e2", busy_a, 1);
      repeat (20) @(negedge clk_fx);
      chk("basic_cnt", cnt_a, 2000); chk("basic_seq", seq_a, 1);
      chk("basic_sat", sat_a, 0);    chk("basic_busy", busy_a, 0);
      chk("basic_cnt4", cnt_b, 15);  chk("basic_sat4", sat_b, 1);
      chk("basic_ovr", ovr_count, 0);

      // saturation on the 4-bit instance, then a non-saturating window
      do_reset("rst_sat");
      repeat (10) @(negedge clk_fx);
      window(20, 20);
      chk("sat_cnt", cnt_b, 15); chk("sat_flag", sat_b, 1); chk("sat_seq", seq_b, 1);
      window(5, 20);
      chk("sat2_cnt", cnt_b, 5); chk("sat2_flag", sat_b, 0); chk("sat2_seq", seq_b, 2);
      chk("sat2_cnt30", cnt_a, 5);

      // overrun with ack withheld
      loop_en = 1'b0;
      do_reset("rst_ovr");
      repeat (10) @(negedge clk_fx);
      ovr_count = 0;
      window(2000, 10);
      window(500, 20);
      chk("ovr_pulses", ovr_count, 1); chk("ovr_cnt", cnt_a, 2000);
      chk("ovr_seq", seq_a, 1);        chk("ovr_busy", busy_a, 1);

      // timeout, then late acknowledge
      do_reset("rst_tmo");
      repeat (10) @(negedge clk_fx);
      window(10, 995);
      chk("tmo_early_err", err_a, 0); chk("tmo_early_busy", busy_a, 1);
      repeat (15) @(negedge clk_fx);
      chk("tmo_err", err_a, 1); chk("tmo_busy", busy_a, 1);
      ack_hold = 1'b1;
      repeat (3) @(negedge clk_fx);
      chk("tmo_ack_busy", busy_a, 0); chk("tmo_ack_err", err_a, 0);

      // gate already high across reset release: no partial window
      loop_en = 1'b1;
      gate_in = 1'b1;
      do_reset("rst_noarm");
      repeat (50) @(negedge clk_fx);
      gate_in = 1'b0;
      repeat (20) @(negedge clk_fx);
      chk("noarm_req", req_a, 0); chk("noarm_seq", seq_a, 0);
      window(100, 20);
      chk("noarm_cnt", cnt_a, 100); chk("noarm_seq2", seq_a, 1);

      // reset mid-window and mid-WAIT
      do_reset("rst_pre");
      repeat (10) @(negedge clk_fx);
      loop_en = 1'b0;
      gate_in = 1'b1;
      repeat (30) @(negedge clk_fx);
      do_reset("rst_midwin");
      gate_in = 1'b0;
      repeat (10) @(negedge clk_fx);
      chk("midwin_req", req_a, 0); chk("midwin_seq", seq_a, 0);
      window(10, 10);
      chk("midwait_busy", busy_a, 1);
      loop_en = 1'b1;
      do_reset("rst_midwait");
      repeat (10) @(negedge clk_fx);
      window(64, 20);
      chk("post_cnt", cnt_a, 64); chk("post_seq", seq_a, 1);
      chk("post_busy", busy_a, 0); chk("post_req", req_a, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
